retire_trace_buffer: RTL and testbench
======================================

# retire_trace_buffer

Debug capture block downstream of the out-of-order core's retirement path: it snoops every register-map destination write and records the last `TRACE_DEPTH` writes in a circular buffer. It can freeze on a user switch or on an optional breakpoint match. While frozen, a key pulse steps a viewing cursor backwards through the history. The viewed entry drives the board's 7-segment decoders. A halt request tells the clock-gating logic to stop the core.

## Interface
- `DATA_WIDTH`, 32, retired data width
- `REG_ADDR_WIDTH`, 5, architectural register index width
- `TRACE_DEPTH`, 16, entries; power of two, ≥2
- `clk` in 1: core clock
- `n_rst` in 1: reset, asynchronous, active-low
- `i_retire_en` in 1: destination write valid this cycle
- `i_retire_rdest` in `REG_ADDR_WIDTH`: destination register
- `i_retire_data` in `DATA_WIDTH`: destination value
- `i_freeze` in 1: level, request freeze
- `i_resume` in 1: single-cycle pulse, leave frozen state
- `i_step` in 1: single-cycle pulse, view next-older entry
- `i_bp_rdest` in `REG_ADDR_WIDTH`: breakpoint register
- `i_bp_data` in `DATA_WIDTH`: breakpoint value
- `o_valid` out 1: viewed entry exists
- `o_rdest` out `REG_ADDR_WIDTH`: viewed entry register
- `o_data` out `DATA_WIDTH`: viewed entry value
- `o_offset` out `$clog2(TRACE_DEPTH)`: age of viewed entry, 0 = newest
- `o_count` out `$clog2(TRACE_DEPTH)+1`: entries held, saturating
- `o_frozen` out 1: in FROZEN
- `o_halt_req` out 1: breakpoint hit, sticky

## Operation
- State machine has two states: CAPTURE (reset) and FROZEN.
- **CAPTURE:**
  - On `i_retire_en`, write {rdest, data} at `wr_ptr`; `wr_ptr` increments modulo `TRACE_DEPTH`; `o_count` increments, saturating at `TRACE_DEPTH`.
  - The view tracks the newest entry with `o_offset` = 0.
  - Moves to FROZEN when `i_freeze` = 1, or on a breakpoint hit (see Configuration).
  - A retire in the same cycle as the transition is still written and becomes the newest entry.
- **FROZEN:**
  - Retires are dropped; `wr_ptr` and `o_count` hold.
  - `i_step` sets `o_offset` to `o_offset` + 1. When `o_offset` = `o_count` − 1, the step wraps `o_offset` to 0.
  - Viewed index = `wr_ptr` − 1 − `o_offset`, modulo depth.
- **Exit from FROZEN:** `i_resume` with `i_freeze` = 0 moves to CAPTURE and resets `o_offset` to 0. `i_resume` while `i_freeze` = 1 is ignored.
- **Same-cycle `i_step` and `i_resume`:** the resume is applied and the step is ignored.
- **Empty buffer:** `o_valid` = 0, `o_data` = 0, `o_rdest` = 0, and steps are ignored.
- Writes to register 0 are recorded like any other write.

## Timing
- All outputs are registered.
- A retire in cycle N is visible on `o_data` in cycle N+1 (CAPTURE).
- A step in cycle N updates the view in cycle N+1.
- Freeze or breakpoint in cycle N gives `o_frozen` = 1 in cycle N+1.
- Reset values: every output 0, `wr_ptr` 0, state CAPTURE. Storage contents are don't-care and are masked by `o_count`.
- Reset mid-operation discards all history immediately (asynchronous).

## Configuration
- Macro `RETIRE_TRACE_BREAKPOINT_EN`.
- **Defined:**
  - In CAPTURE, a retire with `i_retire_rdest` == `i_bp_rdest` and `i_retire_data` == `i_bp_data` is a breakpoint hit.
  - A hit writes the entry, forces FROZEN, and sets `o_halt_req` the next cycle.
  - `o_halt_req` clears on exit from FROZEN.
- **Undefined:** the breakpoint inputs are ignored and `o_halt_req` is tied to 0. The ports remain present.

## Structure
- The shared package holds:
  - `trace_state_t` enum {CAPTURE, FROZEN}
  - `trace_entry_t` packed struct {rdest, data}
- Natural sub-module: `trace_ram`, a `TRACE_DEPTH`×(`REG_ADDR_WIDTH`+`DATA_WIDTH`) register array with one write port and one asynchronous read port. Output registering stays in the parent.

## Test plan
- **Reset, then 3 retires:** retire (x1, 0x11), (x2, 0x22), (x3, 0x33) → `o_count` = 3, `o_data` = 0x33, `o_rdest` = 3, `o_offset` = 0.
- **Wrap:** 20 retires with data = 1..20 at depth 16 → `o_count` = 16. Freeze, then 15 steps → `o_data` = 5. One further step → `o_data` = 20, `o_offset` = 0.
- **Frozen drop:** freeze, retire (x4, 0x44), then resume → `o_count` unchanged and 0x44 never appears.
- **Simultaneous events:**
  - Freeze and retire (x5, 0x55) in the same cycle → frozen view shows 0x55.
  - Step and resume in the same cycle → CAPTURE with `o_offset` = 0.
- **Breakpoint (macro defined):** bp = (x7, 0xDEADBEEF), retire a match → `o_frozen` = 1 and `o_halt_req` = 1 next cycle, `o_data` = 0xDEADBEEF. Resume clears both. With the macro undefined, the same retire gives no freeze.
- **Reset mid-freeze:** frozen with `o_offset` = 3, pulse `n_rst` low → all outputs 0 asynchronously and state is CAPTURE.

Source files
------------

// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retirement trace buffer: capture state and stored entry layout.
// Latency: n/a (types only).
// Backpressure: n/a; the trace path never stalls the core.
package retire_trace_buffer_pkg;

  localparam int TRACE_DATA_WIDTH  = 32;
  localparam int TRACE_RDEST_WIDTH = 5;

  typedef enum logic {
    CAPTURE = 1'b0,
    FROZEN  = 1'b1
  } trace_state_t;

  typedef struct packed {
    logic [TRACE_RDEST_WIDTH-1:0] rdest;
    logic [TRACE_DATA_WIDTH-1:0]  data;
  } trace_entry_t;

endpackage

// File: rtl/retire_trace_buffer_trace_ram.sv
// History storage: DEPTH x WIDTH register array, one synchronous write port, one async read port.
// Latency: write lands on the next edge; read is combinational.
// Backpressure: none; contents are unreset and qualified by the parent's entry count.
module retire_trace_buffer_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: one entry per enabled cycle, no reset needed.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: records the last TRACE_DEPTH register writes, freezes on
// i_freeze (or on a breakpoint match when RETIRE_TRACE_BREAKPOINT_EN is defined), and lets
// i_step walk a viewing cursor backwards. All outputs registered, one cycle after the cause.
// Never backpressures the core; retires arriving while frozen are dropped.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int DATA_WIDTH     = TRACE_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = TRACE_RDEST_WIDTH,
  parameter int TRACE_DEPTH    = 16
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           i_retire_en,
  input  logic [REG_ADDR_WIDTH-1:0]      i_retire_rdest,
  input  logic [DATA_WIDTH-1:0]          i_retire_data,
  input  logic                           i_freeze,
  input  logic                           i_resume,
  input  logic                           i_step,
  input  logic [REG_ADDR_WIDTH-1:0]      i_bp_rdest,
  input  logic [DATA_WIDTH-1:0]          i_bp_data,
  output logic                           o_valid,
  output logic [REG_ADDR_WIDTH-1:0]      o_rdest,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [$clog2(TRACE_DEPTH)-1:0] o_offset,
  output logic [$clog2(TRACE_DEPTH):0]   o_count,
  output logic                           o_frozen,
  output logic                           o_halt_req
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(TRACE_DEPTH);
  localparam logic [PW:0]   ONE_CNT  = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);

  trace_state_t  state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] offset_q, offset_d;
  logic [PW:0]   count_q, count_d;
  logic          halt_q, halt_d;
  logic          valid_q, valid_d;
  trace_entry_t  view_q, view_d;
  trace_entry_t  wr_entry, rd_entry;
  logic [PW-1:0] rd_idx;
  logic          do_write;
  logic          bp_hit;

  assign wr_entry.rdest = i_retire_rdest;
  assign wr_entry.data  = i_retire_data;

`ifdef RETIRE_TRACE_BREAKPOINT_EN
  // A matching retire while capturing is a breakpoint hit.
  assign bp_hit = (state_q == CAPTURE) && i_retire_en &&
                  (i_retire_rdest == i_bp_rdest) && (i_retire_data == i_bp_data);
`else
  logic unused_bp;
  assign unused_bp = ^{i_bp_rdest, i_bp_data};
  assign bp_hit    = 1'b0;
`endif

  // Next-state logic: capture/freeze transitions, pointer, count and cursor updates.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    offset_d = offset_q;
    halt_d   = halt_q;
    do_write = 1'b0;
    case (state_q)
      CAPTURE: begin
        offset_d = '0;
        if (i_retire_en) begin
          do_write = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_PTR;
          if (count_q != FULL_CNT) begin
            count_d = count_q + ONE_CNT;
          end
        end
        if (i_freeze || bp_hit) begin
          state_d = FROZEN;
          halt_d  = bp_hit;
        end
      end
      FROZEN: begin
        if (i_resume && !i_freeze) begin
          state_d  = CAPTURE;
          offset_d = '0;
          halt_d   = 1'b0;
        end else if (i_step && (count_q != '0)) begin
          if ({1'b0, offset_q} == (count_q - ONE_CNT)) begin
            offset_d = '0;
          end else begin
            offset_d = offset_q + ONE_PTR;
          end
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  // View selection: the entry written this cycle is not yet in the array, so bypass it.
  always_comb begin
    rd_idx  = wr_ptr_d - ONE_PTR - offset_d;
    valid_d = (count_d != '0);
    view_d  = '0;
    if (valid_d) begin
      view_d = do_write ? wr_entry : rd_entry;
    end
  end

  retire_trace_buffer_trace_ram #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH ($bits(trace_entry_t))
  ) u_trace_ram (
    .clk     (clk),
    .i_we    (do_write),
    .i_waddr (wr_ptr_q),
    .i_wdata (wr_entry),
    .i_raddr (rd_idx),
    .o_rdata (rd_entry)
  );

  // State and output registers; reset drops all history at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= CAPTURE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      offset_q <= '0;
      halt_q   <= 1'b0;
      valid_q  <= 1'b0;
      view_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      offset_q <= offset_d;
      halt_q   <= halt_d;
      valid_q  <= valid_d;
      view_q   <= view_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_rdest    = view_q.rdest;
  assign o_data     = view_q.data;
  assign o_offset   = offset_q;
  assign o_count    = count_q;
  assign o_frozen   = (state_q == FROZEN);
  assign o_halt_req = halt_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: directed scenarios then random traffic against a queue model.
// Latency: model updated at each rising edge, outputs compared 1ns later.
// Backpressure: n/a.
module tb_retire_trace_buffer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 16;
`ifdef RETIRE_TRACE_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          in_en, in_frz, in_res, in_stp;
  logic [AW-1:0] in_rd, bp_rd;
  logic [DW-1:0] in_dat, bp_dat;
  logic          o_valid, o_frozen, o_halt_req;
  logic [AW-1:0] o_rdest;
  logic [DW-1:0] o_data;
  logic [3:0]    o_offset;
  logic [4:0]    o_count;

  int errors = 0;
  int checks = 0;

  // Reference model: newest entry at the back of the queue.
  logic [AW+DW-1:0] hist[$];
  bit m_frozen, m_halt;
  int m_off;

  always #5 clk = ~clk;

  retire_trace_buffer dut (
    .clk(clk), .n_rst(n_rst),
    .i_retire_en(in_en), .i_retire_rdest(in_rd), .i_retire_data(in_dat),
    .i_freeze(in_frz), .i_resume(in_res), .i_step(in_stp),
    .i_bp_rdest(bp_rd), .i_bp_data(bp_dat),
    .o_valid(o_valid), .o_rdest(o_rdest), .o_data(o_data),
    .o_offset(o_offset), .o_count(o_count),
    .o_frozen(o_frozen), .o_halt_req(o_halt_req)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit hit;
    if (!m_frozen) begin
      hit = BP_EN && in_en && (in_rd == bp_rd) && (in_dat == bp_dat);
      if (in_en) begin
        hist.push_back({in_rd, in_dat});
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      m_off = 0;
      if (in_frz || hit) begin
        m_frozen = 1'b1;
        m_halt   = hit;
      end
    end else if (in_res && !in_frz) begin
      m_frozen = 1'b0;
      m_off    = 0;
      m_halt   = 1'b0;
    end else if (in_stp && hist.size() > 0) begin
      m_off = (m_off == hist.size() - 1) ? 0 : m_off + 1;
    end
  endtask

  task automatic check_all();
    logic [AW+DW-1:0] e;
    e = '0;
    if (hist.size() > 0) e = hist[hist.size() - 1 - m_off];
    check("valid",  64'(o_valid),    64'(hist.size() > 0));
    check("rdest",  64'(o_rdest),    64'(e[AW+DW-1:DW]));
    check("data",   64'(o_data),     64'(e[DW-1:0]));
    check("offset", 64'(o_offset),   64'(m_off));
    check("count",  64'(o_count),    64'(hist.size()));
    check("frozen", 64'(o_frozen),   64'(m_frozen));
    check("halt",   64'(o_halt_req), 64'(m_halt));
  endtask

  task automatic cycle(input bit en, input logic [AW-1:0] rd, input logic [DW-1:0] dat,
                       input bit frz, input bit res, input bit stp);
    in_en = en; in_rd = rd; in_dat = dat; in_frz = frz; in_res = res; in_stp = stp;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  64'(o_valid),    64'd0);
    check({tag, "_rdest"},  64'(o_rdest),    64'd0);
    check({tag, "_data"},   64'(o_data),     64'd0);
    check({tag, "_offset"}, 64'(o_offset),   64'd0);
    check({tag, "_count"},  64'(o_count),    64'd0);
    check({tag, "_frozen"}, 64'(o_frozen),   64'd0);
    check({tag, "_halt"},   64'(o_halt_req), 64'd0);
  endtask

  task automatic model_clear();
    hist.delete();
    m_frozen = 1'b0;
    m_halt   = 1'b0;
    m_off    = 0;
  endtask

  initial begin
    bit frz_lvl;
    n_rst = 1'b0;
    in_en = 0; in_rd = '0; in_dat = '0; in_frz = 0; in_res = 0; in_stp = 0;
    bp_rd = 5'd7; bp_dat = 32'hDEADBEEF;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Three retires: newest shows immediately.
    cycle(1, 5'd1, 32'h11, 0, 0, 0);
    cycle(1, 5'd2, 32'h22, 0, 0, 0);
    cycle(1, 5'd3, 32'h33, 0, 0, 0);
    check("three_count", 64'(o_count), 64'd3);
    check("three_data",  64'(o_data),  64'h33);
    check("three_rdest", 64'(o_rdest), 64'd3);

    // Wrap: 20 retires, freeze, walk back to the oldest, then wrap to newest.
    for (int i = 1; i <= 20; i++) cycle(1, 5'(i), 32'(i), 0, 0, 0);
    check("wrap_count", 64'(o_count), 64'd16);
    cycle(0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 15; i++) cycle(0, '0, '0, 1, 0, 1);
    check("wrap_oldest", 64'(o_data), 64'd5);
    cycle(0, '0, '0, 1, 0, 1);
    check("wrap_newest", 64'(o_data), 64'd20);
    check("wrap_offset0", 64'(o_offset), 64'd0);

    // Retire while frozen is dropped; resume while freeze held is ignored.
    cycle(1, 5'd4, 32'h44, 1, 0, 0);
    cycle(0, '0, '0, 1, 1, 0);
    check("resume_ignored", 64'(o_frozen), 64'd1);
    cycle(0, '0, '0, 0, 1, 0);
    check("drop_count", 64'(o_count), 64'd16);
    check("drop_data",  64'(o_data),  64'd20);

    // Freeze with a same-cycle retire, then step+resume together.
    cycle(1, 5'd5, 32'h55, 1, 0, 0);
    check("frz_retire_data", 64'(o_data), 64'h55);
    cycle(0, '0, '0, 1, 0, 1);
    cycle(0, '0, '0, 0, 1, 1);
    check("step_resume_frozen", 64'(o_frozen), 64'd0);
    check("step_resume_offset", 64'(o_offset), 64'd0);

    // Breakpoint match (freezes only when the feature is built in).
    cycle(1, 5'd7, 32'hDEADBEEF, 0, 0, 0);
    check("bp_frozen", 64'(o_frozen),   64'(BP_EN));
    check("bp_halt",   64'(o_halt_req), 64'(BP_EN));
    check("bp_data",   64'(o_data),     64'hDEADBEEF);
    cycle(0, '0, '0, 0, 1, 0);
    check("bp_clear", 64'({o_frozen, o_halt_req}), 64'd0);

    // Reset in the middle of a freeze with the cursor at 3.
    cycle(0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 1, 0, 1);
    check("pre_reset_offset", 64'(o_offset), 64'd3);
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_clear();
    in_frz = 0; in_stp = 0;
    @(negedge clk);
    n_rst = 1'b1;

    // Steps on an empty frozen buffer do nothing.
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 1);
    cycle(0, '0, '0, 1, 0, 1);
    check("empty_offset", 64'(o_offset), 64'd0);
    cycle(0, '0, '0, 0, 1, 0);

    // Random traffic.
    frz_lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bit en, res, stp;
      logic [AW-1:0] rd;
      logic [DW-1:0] dat;
      if ($urandom_range(0, 19) == 0) frz_lvl = ~frz_lvl;
      en  = ($urandom_range(0, 9) < 6);
      res = ($urandom_range(0, 9) == 0);
      stp = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 49) == 0) begin
        rd = bp_rd; dat = bp_dat;
      end else begin
        rd = 5'($urandom);
        dat = $urandom;
      end
      cycle(en, rd, dat, frz_lvl, res, stp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
